// File: rtl/multi_port_fifo_if.sv
// Bundled push/pop lanes and occupancy status for multi_port_fifo.
// The slave modport is the FIFO side, and the master modport is the producer/consumer side.
interface multi_port_fifo_if #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned WR_PORTS = 2,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned MAX_CNT  = 3
);
    localparam int unsigned CNT_BITS = $clog2(MAX_CNT + 1);
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    logic [WR_PORTS-1:0]       wr_en;
    logic [WR_PORTS*WIDTH-1:0] wr_data;
    logic [WR_PORTS-1:0]       wr_valid;
    logic [RD_PORTS-1:0]       rd_en;
    logic [RD_PORTS*WIDTH-1:0] rd_data;
    logic [RD_PORTS-1:0]       rd_valid;
    logic [CNT_BITS-1:0]       spots;
    logic [CW-1:0]             count;
    logic                      full;
    logic                      empty;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_valid, rd_data, rd_valid, spots, count, full, empty
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_valid, rd_data, rd_valid, spots, count, full, empty
    );
endinterface

// File: rtl/multi_port_fifo.sv
// Multi-lane in-order FIFO: up to WR_PORTS pushes and RD_PORTS pops per cycle, with enabled lanes compacted by rank.
// Define MULTI_PORT_FIFO_BYPASS_EN to let reads beyond the current occupancy take same-cycle accepted writes.
module multi_port_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned WR_PORTS = 2,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned MAX_CNT  = 3
) (
    input logic             clock,
    input logic             reset,
    multi_port_fifo_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam int unsigned CNT_BITS = $clog2(MAX_CNT + 1);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [CW:0]      count_next;
    logic [CW:0]      n_wr;
    logic [CW:0]      n_rd;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_slot [WR_PORTS];

    // Accepted writes always form a contiguous rank prefix, so tail + rank is the slot for each accepted write.
    always_comb begin : write_lanes
        int unsigned rank;
        int unsigned space;
        rank          = 0;
        space         = DEPTH - 32'(count);
        bus.wr_valid  = '0;
        n_wr          = '0;
        for (int unsigned i = 0; i < WR_PORTS; i++) begin
            wr_slot[i] = tail + AW'(rank);
            if (bus.wr_en[i]) begin
                if (!reset && rank < space) begin
                    bus.wr_valid[i] = 1'b1;
                    n_wr            = n_wr + (CW+1)'(1);
                end
                rank++;
            end
        end
    end

    always_comb begin : read_lanes
        int unsigned   rank;
        logic [AW-1:0] slot;
        rank         = 0;
        slot         = '0;
        bus.rd_valid = '0;
        bus.rd_data  = '0;
        n_rd         = '0;
        for (int unsigned i = 0; i < RD_PORTS; i++) begin
            if (bus.rd_en[i]) begin
                slot = head + AW'(rank);
                bus.rd_data[i*WIDTH +: WIDTH] = mem[slot];
                if (!reset && rank < 32'(count)) begin
                    bus.rd_valid[i] = 1'b1;
                    n_rd            = n_rd + (CW+1)'(1);
                end
`ifdef MULTI_PORT_FIFO_BYPASS_EN
                // head + count == tail, so a slot match against an accepted write lane selects write rank (rank - count).
                else if (!reset) begin
                    for (int unsigned j = 0; j < WR_PORTS; j++) begin
                        if (bus.wr_valid[j] && wr_slot[j] == slot) begin
                            bus.rd_valid[i]               = 1'b1;
                            bus.rd_data[i*WIDTH +: WIDTH] = bus.wr_data[j*WIDTH +: WIDTH];
                            n_rd                          = n_rd + (CW+1)'(1);
                        end
                    end
                end
`endif
                rank++;
            end
        end
    end

    always_comb begin
        count_next = {1'b0, count} + n_wr - n_rd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + n_rd[AW-1:0];
            tail  <= tail + n_wr[AW-1:0];
            count <= count_next[CW-1:0];
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < WR_PORTS; i++) begin
            if (bus.wr_valid[i]) begin
                mem[wr_slot[i]] <= bus.wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin : credit
        int unsigned space;
        space     = DEPTH - 32'(count);
        bus.spots = (space > MAX_CNT) ? CNT_BITS'(MAX_CNT) : CNT_BITS'(space);
    end

    assign bus.count = count;
    assign bus.full  = (count == CW'(DEPTH));
    assign bus.empty = (count == '0);
endmodule
